// File: rtl/imm_pkg.sv
// imm_pkg: shared constants and types for the immediate generator.
//   - RV32I/RV64I major opcodes and the funct3 values that select
//     sub-formats inside OP-IMM and SYSTEM.
//   - imm_fmt_t: the format code that travels with every decoded immediate.
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_SLLI = 3'b001;  // OP-IMM shift left
    localparam logic [2:0] F3_SRXI = 3'b101;  // OP-IMM shift right (srli/srai)
    localparam logic [2:0] F3_PRIV = 3'b000;  // SYSTEM ecall/ebreak/xRET

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSRI  = 3'd7
    } imm_fmt_t;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate extraction for one instruction.
//   ins_i      [31:0]     instruction word
//   imm_o      [XLEN-1:0] decoded immediate (0 when the format has none)
//   fmt_o      imm_fmt_t  format code
//   illegal_o             opcode is not one this block recognises
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ins_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = ins_i[6:0];
    assign funct3 = ins_i[14:12];

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        unique case (opcode)
            OP_IMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
                    // Shift amount only; funct7 (which carries the srai bit)
                    // must not leak into the immediate. RV64 widens it to 6 bits.
                    fmt_o = FMT_SHAMT;
                    if (XLEN == 32) imm_o = XLEN'(ins_i[24:20]);
                    else            imm_o = XLEN'(ins_i[25:20]);
                end else begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(ins_i[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm_o = XLEN'($signed(ins_i[31:20]));
            end
            OP_SYSTEM: begin
                if (funct3 == F3_PRIV) begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(ins_i[31:20]));
                end else if (funct3[2]) begin
                    // csrrwi/csrrsi/csrrci: the rs1 field is a 5-bit uimm.
                    fmt_o = FMT_CSRI;
                    imm_o = XLEN'(ins_i[19:15]);
                end
                // Register CSR ops carry no immediate but are still legal.
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm_o = XLEN'($signed({ins_i[31:25], ins_i[11:7]}));
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = XLEN'($signed({ins_i[31], ins_i[7], ins_i[30:25],
                                       ins_i[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                // 32-bit value first, then sign-extend to XLEN (RV64 lui).
                fmt_o = FMT_U;
                imm_o = XLEN'($signed({ins_i[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm_o = XLEN'($signed({ins_i[31], ins_i[19:12], ins_i[20],
                                       ins_i[30:21], 1'b0}));
            end
            OP_REG, OP_FENCE: begin
                // Legal, no immediate.
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes instruction immediates and buffers the results in a
// DEPTH-entry circular FIFO with valid/ready on both sides.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake, in_ins [31:0] instruction
//   out_valid/out_ready downstream handshake for the FIFO head
//   out_imm [XLEN-1:0], out_fmt [2:0] (imm_fmt_t), out_illegal, out_ins [31:0]
//
// Handshake: a transfer happens on a port only in a cycle where its valid and
// ready are both high at the rising edge. Valid never waits for ready; once
// out_valid is high the head entry holds until it is taken. in_ready is a
// function of registered state only, so it never depends on out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_ins
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .ins_i     (in_ins),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    // Storage is not reset; out_valid qualifies it.
    logic [XLEN-1:0] imm_mem [DEPTH];
    logic [2:0]      fmt_mem [DEPTH];
    logic            ill_mem [DEPTH];
    logic [31:0]     ins_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Holds in_ready low through reset and releases it on the first edge after.
    logic             live_q;

    logic push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = live_q && (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr_q] <= dec_imm;
            fmt_mem[wr_ptr_q] <= dec_fmt;
            ill_mem[wr_ptr_q] <= dec_illegal;
            ins_mem[wr_ptr_q] <= in_ins;
        end
    end

    assign out_imm     = imm_mem[rd_ptr_q];
    assign out_fmt     = fmt_mem[rd_ptr_q];
    assign out_illegal = ill_mem[rd_ptr_q];
    assign out_ins     = ins_mem[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share the same
// stimulus and handshake inputs; each has its own expected queue.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_ins;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_ins32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_ins64;
    logic [2:0]  out_fmt64;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected entry: {ins[31:0], illegal, fmt[2:0], imm[63:0]}
    logic [99:0] exp32_q[$];
    logic [99:0] exp64_q[$];

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready32), .in_ins(in_ins),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_illegal32), .out_ins(out_ins32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_ins(in_ins),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_ins(out_ins64)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [99:0] model(input logic [31:0] ins, input int xlen);
        logic signed [63:0] s;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [2:0]  f3;
        s = '0; imm = '0; fmt = 3'd0; ill = 1'b0; f3 = ins[14:12];
        case (ins[6:0])
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = 3'd6;
                    imm = (xlen == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]);
                end else begin
                    fmt = 3'd1; s = {ins[31:20], 52'b0}; imm = s >>> 52;
                end
            end
            7'h03, 7'h67: begin fmt = 3'd1; s = {ins[31:20], 52'b0}; imm = s >>> 52; end
            7'h73: begin
                if (f3 == 3'd0) begin
                    fmt = 3'd1; s = {ins[31:20], 52'b0}; imm = s >>> 52;
                end else if (f3[2]) begin
                    fmt = 3'd7; imm = 64'(ins[19:15]);
                end
            end
            7'h23: begin fmt = 3'd2; s = {ins[31:25], ins[11:7], 52'b0}; imm = s >>> 52; end
            7'h63: begin
                fmt = 3'd3;
                s = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0};
                imm = s >>> 51;
            end
            7'h37, 7'h17: begin fmt = 3'd4; s = {ins[31:12], 44'b0}; imm = s >>> 32; end
            7'h6f: begin
                fmt = 3'd5;
                s = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0};
                imm = s >>> 43;
            end
            7'h33, 7'h0f: begin end
            default: ill = 1'b1;
        endcase
        if (xlen == 32) imm[63:32] = 32'b0;
        return {ins, ill, fmt, imm};
    endfunction

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Sampled on the falling edge: entries are queued right after their
    // accepting edge and popped just before the edge that takes them.
    always @(negedge clk) begin
        logic [99:0] e;
        if (rst_n) begin
            chk("out32_valid", 64'(out_valid32), 64'(exp32_q.size() != 0));
            chk("out64_valid", 64'(out_valid64), 64'(exp64_q.size() != 0));
            if (out_valid32 && out_ready && exp32_q.size() != 0) begin
                e = exp32_q.pop_front();
                chk("out32_ins", 64'(out_ins32), 64'(e[99:68]));
                chk("out32_ill", 64'(out_illegal32), 64'(e[67]));
                chk("out32_fmt", 64'(out_fmt32), 64'(e[66:64]));
                chk("out32_imm", 64'(out_imm32), 64'(e[31:0]));
            end
            if (out_valid64 && out_ready && exp64_q.size() != 0) begin
                e = exp64_q.pop_front();
                chk("out64_ins", 64'(out_ins64), 64'(e[99:68]));
                chk("out64_ill", 64'(out_illegal64), 64'(e[67]));
                chk("out64_fmt", 64'(out_fmt64), 64'(e[66:64]));
                chk("out64_imm", out_imm64, e[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns #1 after the accepting edge. If the FIFO stays full for two
    // cycles the downstream side is released so random stalls cannot deadlock.
    task automatic push(input logic [31:0] ins);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_ins   = ins;
        @(negedge clk);
        while (!(in_ready32 && in_ready64) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n >= 2) out_ready = 1'b1;
            @(negedge clk);
        end
        chk("push_wait_bound", 64'(n < 40), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (n < 40) begin
            exp32_q.push_back(model(ins, 32));
            exp64_q.push_back(model(ins, 64));
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        out_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((exp32_q.size() != 0 || exp64_q.size() != 0 || out_valid32 || out_valid64) && n < 50);
        chk("drain_bound", 64'(n < 50), 64'd1);
    endtask

    // Pushes one instruction into an empty FIFO and checks the head one
    // cycle after acceptance against literal expected values.
    task automatic directed(input string tag, input logic [31:0] ins,
                            input logic [63:0] imm32, input logic [63:0] imm64,
                            input logic [2:0] fmt, input logic ill);
        wait_empty();
        out_ready = 1'b0;
        push(ins);
        chk({tag, "_valid"}, 64'(out_valid32 & out_valid64), 64'd1);
        chk({tag, "_imm32"}, 64'(out_imm32), imm32);
        chk({tag, "_imm64"}, out_imm64, imm64);
        chk({tag, "_fmt32"}, 64'(out_fmt32), 64'(fmt));
        chk({tag, "_fmt64"}, 64'(out_fmt64), 64'(fmt));
        chk({tag, "_ill"},   64'(out_illegal32), 64'(ill));
        out_ready = 1'b1;
        wait_empty();
    endtask

    // ---------------- stimulus ----------------
    localparam logic [31:0] INS_A = 32'h0050_0113;  // addi x2,x0,5
    localparam logic [31:0] INS_B = 32'hFE00_0EE3;  // beq, offset -4
    localparam logic [31:0] INS_C = 32'h8000_00B7;  // lui x1,0x80000

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] r;
        logic [99:0] ea;
        int t0;

        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f, 7'h7f};
        rst_n = 1'b0; in_valid = 1'b0; in_ins = '0; out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready32", 64'(in_ready32), 64'd0);
        chk("rst_in_ready64", 64'(in_ready64), 64'd0);
        chk("rst_out_valid32", 64'(out_valid32), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("post_rst_pre_edge_ready", 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_first_edge_ready32", 64'(in_ready32), 64'd1);
        chk("post_rst_first_edge_ready64", 64'(in_ready64), 64'd1);

        // Directed decode vectors
        directed("addi_m1", 32'hFFF0_0093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        directed("srai3",   32'h4030_D093, 64'h3, 64'h3, 3'd6, 1'b0);
        directed("slli63",  32'h03F0_9093, 64'h1F, 64'h3F, 3'd6, 1'b0);
        directed("lui",     INS_C, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        directed("beq_m4",  INS_B, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        directed("csrwi15", 32'h0007_D073, 64'hF, 64'hF, 3'd7, 1'b0);
        directed("sw_m1",   32'hFE11_2FA3, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b0);
        directed("jal_m2",  32'hFFFF_F0EF, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 3'd5, 1'b0);
        directed("add_r",   32'h0020_80B3, 64'h0, 64'h0, 3'd0, 1'b0);
        directed("csrrw",   32'h3400_1073, 64'h0, 64'h0, 3'd0, 1'b0);
        directed("op_7f",   32'hFFFF_FFFF, 64'h0, 64'h0, 3'd0, 1'b1);

        // Back-pressure: two entries fill the FIFO, third must wait
        wait_empty();
        out_ready = 1'b0;
        push(INS_A);
        push(INS_B);
        chk("full_in_ready32", 64'(in_ready32), 64'd0);
        chk("full_in_ready64", 64'(in_ready64), 64'd0);
        ea = model(INS_A, 64);
        in_valid = 1'b1;
        in_ins   = INS_C;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready32), 64'd0);
            chk("stall_head_ins", 64'(out_ins32), 64'(INS_A));
            chk("stall_head_imm", out_imm64, ea[63:0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("ready_indep_of_out_ready", 64'(in_ready32), 64'd0);
        push(INS_C);
        wait_empty();
        chk("bp_no_dup32", 64'(exp32_q.size()), 64'd0);

        // Full throughput with out_ready held high
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 11)];
            push(r);
        end
        chk("throughput_cycles", 64'(cyc - t0), 64'd8);
        wait_empty();

        // Random stream with random downstream stalls and input gaps
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 11)];
            push(r);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_empty();

        // Reset with two entries buffered
        out_ready = 1'b0;
        push(INS_A);
        push(INS_B);
        #3 rst_n = 1'b0;
        exp32_q.delete();
        exp64_q.delete();
        #1;
        chk("midrst_out_valid32", 64'(out_valid32), 64'd0);
        chk("midrst_out_valid64", 64'(out_valid64), 64'd0);
        chk("midrst_in_ready", 64'(in_ready32), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_back", 64'(in_ready32), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("midrst_no_reappear", 64'(out_valid32 | out_valid64), 64'd0);
        end

        // Traffic resumes cleanly after the reset
        push(INS_C);
        chk("post_rst_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
